// File: rtl/mem_op_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mem_op_sequencer_pkg
// Shared definitions for the memory-operation sequencer and the memory-side
// models that track it: operation encodings, the sequencer state enum, the
// sequence-length constants and the seq_len() helper that turns an operation
// and an effective core count into the memory FSM's active-state count.
// ---------------------------------------------------------------------------
package mem_op_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_COMM  = 2'b01,
    OP_DIFF  = 2'b10,
    OP_STORE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    GUARD = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int COMM_LEN      = 3;
  localparam int DIFF_PER_CORE = 3;
  localparam int MAX_CORES     = 4;

  // Number of active memory-FSM states for an operation; n is 1..4.
  // A nop has no memory-side sequence, so its length is zero.
  function automatic logic [3:0] seq_len(input op_e op, input logic [2:0] n);
    logic [3:0] len;
    case (op)
      OP_COMM:  len = 4'(COMM_LEN);
      OP_DIFF:  len = 4'(DIFF_PER_CORE * int'(n));
      OP_STORE: len = {1'b0, n};
      default:  len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_op_sequencer.sv
// ---------------------------------------------------------------------------
// mem_op_sequencer
// Accepts one memory-operation request at a time, presents it to the memory
// FSM on memory_state for exactly one cycle, then shadows the memory FSM's
// fixed-length sequence so the control unit can stall on mem_busy and resume
// on mem_done. After reset it holds busy for GUARD_CYCLES cycles so a memory
// FSM that was mid-sequence (it has no reset) can drain first.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   req          : request level, held until req_ack
//   op           : operation code (01 comm, 10 diff, 11 store, 00 nop)
//   NoC          : number of active cores, sampled at acceptance
//   memory_state : op code to the memory FSM, non-zero one cycle per op
//   req_ack      : one-cycle pulse when a request is taken
//   mem_busy     : high whenever the sequencer is not IDLE
//   mem_done     : one-cycle pulse, memory FSM back in fetch
// ---------------------------------------------------------------------------
module mem_op_sequencer
  import mem_op_sequencer_pkg::*;
#(
  parameter int GUARD_CYCLES = 12,
  parameter int NOC_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [NOC_W-1:0] NoC,
  output logic [1:0]       memory_state,
  output logic             req_ack,
  output logic             mem_busy,
  output logic             mem_done
);

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

  state_e     state;
  state_e     next_state;
  logic [3:0] count;
  logic [3:0] next_count;
  op_e        op_lat;
  logic [2:0] n_lat;
  logic [2:0] n_eff;
  logic       accept;

  logic [1:0] memory_state_nx;
  logic       req_ack_nx;
  logic       mem_busy_nx;
  logic       mem_done_nx;

  assign accept = (state == IDLE) && req;

  // Effective core count: 1..3 pass through, everything else counts as 4.
  always_comb begin
    if ((NoC == NOC_W'(1)) || (NoC == NOC_W'(2)) || (NoC == NOC_W'(3))) begin
      n_eff = {1'b0, NoC[1:0]};
    end else begin
      n_eff = 3'(MAX_CORES);
    end
  end

  // State register, sequence counter and the operation latched at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= GUARD;
      count  <= GUARD_LOAD;
      op_lat <= OP_NOP;
      n_lat  <= 3'(MAX_CORES);
    end else begin
      state <= next_state;
      count <= next_count;
      if (accept) begin
        op_lat <= op_e'(op);
        n_lat  <= n_eff;
      end
    end
  end

  // Next-state and counter logic. The counter is loaded with L-1 in ISSUE so
  // that WAIT lasts exactly L cycles, in lock-step with the memory FSM.
  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      GUARD: begin
        if (count == 4'd0) begin
          next_state = IDLE;
        end else begin
          next_count = count - 4'd1;
        end
      end
      IDLE: begin
        if (req) begin
          next_state = ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: begin
        if (op_lat == OP_NOP) begin
          next_state = DONE;
        end else begin
          next_state = WAIT;
          next_count = seq_len(op_lat, n_lat) - 4'd1;
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          next_state = DONE;
        end else begin
          next_count = count - 4'd1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        // Unreachable encoding: fall back to a full guard period.
        next_state = GUARD;
        next_count = GUARD_LOAD;
      end
    endcase
  end

  // Output decode from the next state. ISSUE is only ever entered from IDLE
  // on acceptance, so the op being latched this edge is the live op input.
  always_comb begin
    memory_state_nx = 2'b00;
    req_ack_nx      = 1'b0;
    mem_done_nx     = 1'b0;
    mem_busy_nx     = 1'b1;
    case (next_state)
      ISSUE: begin
        memory_state_nx = op;
        req_ack_nx      = 1'b1;
      end
      DONE: begin
        mem_done_nx = 1'b1;
      end
      IDLE: begin
        mem_busy_nx = 1'b0;
      end
      default: begin
        mem_busy_nx = 1'b1;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memory_state <= 2'b00;
      req_ack      <= 1'b0;
      mem_busy     <= 1'b1;
      mem_done     <= 1'b0;
    end else begin
      memory_state <= memory_state_nx;
      req_ack      <= req_ack_nx;
      mem_busy     <= mem_busy_nx;
      mem_done     <= mem_done_nx;
    end
  end

endmodule

// File: tb/tb_mem_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_op_sequencer
// Directed plus randomized bench for mem_op_sequencer. Expected outputs come
// from a cycle-index model: for an operation accepted at cycle T with
// sequence length L, cycle T+k shows memory_state/req_ack at k=1, mem_done at
// k=L+2, mem_busy for k<=L+2 and IDLE again at k=L+3.
// ---------------------------------------------------------------------------
module tb_mem_op_sequencer;

  localparam int GUARD = 12;
  localparam int NW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req;
  logic [1:0]    op;
  logic [NW-1:0] NoC;
  logic [1:0]    memory_state;
  logic          req_ack;
  logic          mem_busy;
  logic          mem_done;

  int tests  = 0;
  int failed = 0;

  mem_op_sequencer #(.GUARD_CYCLES(GUARD), .NOC_W(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .op           (op),
    .NoC          (NoC),
    .memory_state (memory_state),
    .req_ack      (req_ack),
    .mem_busy     (mem_busy),
    .mem_done     (mem_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string ctx, input logic [1:0] ems, input logic eack,
                          input logic ebusy, input logic edone);
    chk({ctx, " memory_state"}, memory_state, ems);
    chk({ctx, " req_ack"}, {1'b0, req_ack}, {1'b0, eack});
    chk({ctx, " mem_busy"}, {1'b0, mem_busy}, {1'b0, ebusy});
    chk({ctx, " mem_done"}, {1'b0, mem_done}, {1'b0, edone});
  endtask

  // Sequence length from the operation rules.
  function automatic int model_len(input logic [1:0] o, input logic [NW-1:0] noc);
    int n;
    n = (noc >= 1 && noc <= 3) ? int'(noc) : 4;
    case (o)
      2'b01:   return 3;
      2'b10:   return 3 * n;
      2'b11:   return n;
      default: return 0;
    endcase
  endfunction

  // Called just after reset release: busy for GUARD cycles, then IDLE.
  task automatic guard_check();
    for (int j = 0; j < GUARD; j++) begin
      chk_outs($sformatf("guard%0d", j), 2'b00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    chk_outs("guard_end", 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Starts at a negedge of an IDLE cycle; ends at the negedge of the IDLE
  // cycle after DONE. With hold set, req stays high throughout.
  task automatic run_op(input logic [1:0] o, input logic [NW-1:0] noc, input bit hold);
    int len;
    len = model_len(o, noc);
    req = 1'b1;
    op  = o;
    NoC = noc;
    for (int k = 1; k <= len + 3; k++) begin
      @(negedge clk);
      chk_outs($sformatf("op%0b noc%0d k%0d", o, noc, k),
               (k == 1) ? o : 2'b00, k == 1, k <= len + 2, k == len + 2);
      if (k == 1 && !hold) req = 1'b0;
      // Scramble inputs after acceptance; the op in flight must not change.
      op  = 2'($urandom);
      NoC = NW'($urandom_range(0, 9));
    end
  endtask

  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk_outs($sformatf("gap%0d", i), 2'b00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [1:0]    ro;
    logic [NW-1:0] rn;
    bit            rh;
    req = 1'b0;
    op  = 2'b00;
    NoC = '0;

    // Reset state.
    #1 rst = 1'b1;
    #1 chk_outs("reset", 2'b00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 guard_check();

    // Directed operations.
    run_op(2'b01, 16'd0, 1'b0);      // comm, L=3
    run_op(2'b10, 16'd3, 1'b0);      // diff n=3, L=9, NoC scrambled in WAIT
    run_op(2'b11, 16'd2, 1'b0);      // store L=2
    run_op(2'b11, 16'd0, 1'b0);      // store NoC=0 -> L=4
    run_op(2'b11, 16'd7, 1'b0);      // store NoC=7 -> L=4
    idle_gap(2);
    run_op(2'b10, 16'd4, 1'b1);      // diff L=12 with req held
    run_op(2'b01, 16'd1, 1'b0);      // re-accepted immediately
    run_op(2'b00, 16'd2, 1'b0);      // nop
    run_op(2'b11, 16'hFFFF, 1'b0);   // large NoC -> 4

    // Reset in WAIT of a diff: immediate reset values, no mem_done, guard.
    req = 1'b1; op = 2'b10; NoC = 16'd3;
    @(negedge clk);
    chk_outs("rst_op issue", 2'b10, 1'b1, 1'b1, 1'b0);
    req = 1'b0;
    repeat (4) @(negedge clk);
    chk_outs("rst_op wait", 2'b00, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1 chk_outs("rst_mid", 2'b00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 guard_check();

    // Randomized operations.
    for (int t = 0; t < 30; t++) begin
      ro = 2'($urandom_range(0, 3));
      rn = ($urandom_range(0, 3) == 0) ? NW'($urandom) : NW'($urandom_range(0, 7));
      rh = ($urandom_range(0, 2) == 0);
      run_op(ro, rn, rh);
      if (!rh) idle_gap($urandom_range(0, 2));
    end
    req = 1'b0;
    idle_gap(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_op_sequencer.md
# mem_op_sequencer

Upstream issuer for the memory-control FSM. It accepts one memory-operation request at a time from the core control unit and presents it on `memory_state` for exactly one cycle. It then tracks the memory FSM's fixed-length sequence (comm, diff or store, scaled by core count) so the control unit can stall on `mem_busy` and resume on `mem_done`. It never overlaps operations, and after reset it guards against a memory FSM that is still draining.

## Interface
- `GUARD_CYCLES`, default 12: busy hold-off after reset release; equals the longest memory sequence.
- `NOC_W`, default 16: width of the core-count input.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `req` input, 1: operation request; level, held until `req_ack`.
- `op` input, 2: 01 comm, 10 diff, 11 store, 00 nop; valid while `req`=1.
- `NoC` input, `NOC_W`: number of active cores; sampled at acceptance.
- `memory_state` output, 2: operation code to the memory FSM; non-zero for one cycle per operation.
- `req_ack` output, 1: one-cycle pulse; the request was taken.
- `mem_busy` output, 1: high while not IDLE.
- `mem_done` output, 1: one-cycle pulse; the memory FSM is back in fetch.

## Operation
- States:
  - GUARD: counter runs down from `GUARD_CYCLES`-1; go to IDLE at 0.
  - IDLE: if `req`=1, latch `op` and the effective count n, then go to ISSUE.
  - ISSUE: drive `memory_state`=op and `req_ack`=1. Load the counter with L-1, then go to WAIT. If op=00, skip straight to DONE.
  - WAIT: decrement the counter; go to DONE at 0.
  - DONE: `mem_done`=1; go to IDLE.
- Effective count: n = `NoC` if `NoC` is 1, 2 or 3; n = 4 otherwise, including 0 and any value above 4.
- Sequence length L:
  - comm: 3.
  - diff: 3n (3, 6, 9 or 12).
  - store: n.
- Counter is 4 bits; L is at most 12, so the counter never wraps.
- All outputs are registered and decoded from the next state.
- `memory_state` is 00 in every state except ISSUE.
- `mem_busy` = (state != IDLE), registered.
- `req` in any state other than IDLE is ignored. No queueing.
- If `req` is still high in the IDLE cycle after DONE, it is accepted as a new request. The requester must drop `req` in the cycle after `req_ack`.
- Changes to `NoC` or `op` after acceptance have no effect on the operation in flight.
- Reset:
  - Reset values: `memory_state`=00, `req_ack`=0, `mem_done`=0, `mem_busy`=1, counter = `GUARD_CYCLES`-1, state GUARD.
  - On release, the block spends `GUARD_CYCLES` cycles in GUARD, then IDLE.
  - Reset mid-operation aborts tracking with no `mem_done`. The guard covers the memory FSM, which has no reset, finishing its sequence.

## Timing
- Cycle T: IDLE with `req`=1.
- T+1: ISSUE. `memory_state`=op and `req_ack`=1; the memory FSM samples op at the end of T+1.
- T+2 to T+1+L: WAIT, aligned cycle-for-cycle with the memory FSM's L active states.
- T+2+L: DONE. `mem_done`=1 and the memory FSM is in fetch.
- T+3+L: IDLE, with `mem_busy` falling at that edge. Earliest next ISSUE is T+4+L.
- Nop: ISSUE at T+1 with `memory_state`=00, DONE at T+2.
- Request-to-done latency is L+2 cycles. Back-to-back operations have a period of L+3 cycles.

## Structure
- Shared package holds:
  - op encodings: OP_NOP, OP_COMM, OP_DIFF, OP_STORE.
  - state enum: GUARD, IDLE, ISSUE, WAIT, DONE.
  - constants COMM_LEN=3, DIFF_PER_CORE=3, MAX_CORES=4.
  - function `seq_len(op, n)`, reused by the memory-side bench model.
- No sub-module. A single FSM-plus-counter module is the natural size.

## Test plan
- Comm: release reset and wait 12 guard cycles; `req`=1, op=01. Expect `req_ack` and `memory_state`=01 in ISSUE, 3 WAIT cycles, `mem_done` 5 cycles after acceptance.
- Diff with `NoC`=3: 9 WAIT cycles, `mem_done` at T+11. Change `NoC` to 1 during WAIT; timing must not change.
- Store with `NoC`=2: 2 WAIT cycles, `mem_done` at T+4. Repeat with `NoC`=0 and `NoC`=7: both must give L=4.
- Diff with `NoC`=4 and `req` held high through busy: exactly one `req_ack`, `mem_done` at T+14, then re-acceptance at T+15.
- Assert `rst` during WAIT of a diff: all outputs go to reset values immediately, there is no `mem_done`, and `mem_busy` stays high for 12 cycles after release.
- Nop, op=00: `memory_state` stays 00, `req_ack` at T+1, `mem_done` at T+2.
